// File: rtl/alu4_nibble_seq.sv
// Sequences WIDTH-bit operations through an external 4-bit ALU, LSB nibble first.
// Optional `ALU4_NIBBLE_SEQ_OPCNT_EN adds a 16-bit response-handshake counter output op_count.
//
// state | meaning
// IDLE  | ready for a command, ALU inputs held at 0
// RUN   | one nibble per cycle through the ALU, carry chained
// DONE  | response presented until resp_ready
module alu4_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_carry,
    output logic             resp_overflow,
    output logic             resp_zero,
    output logic             resp_size,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_c,
    output logic             alu_cin,
    input  logic [3:0]       alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow
`ifdef ALU4_NIBBLE_SEQ_OPCNT_EN
    ,
    output logic [15:0]      op_count
`endif
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 2) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_q, b_q, res_q, res_nx;
    logic [2:0]       op_q;
    logic [IW-1:0]    idx;
    logic             carry_q;
    logic             carry_f, ovf_f, zero_f, size_f;
    logic             arith, inv_b, last;

    logic             req_ready_i, resp_valid_i, alu_cin_i;
    logic [3:0]       alu_a_i, alu_b_i;
    logic [2:0]       alu_c_i;

    // sub, less-than and equal all run as a + ~b + 1 through the ALU adder
    assign inv_b  = (op_q == 3'b001) || (op_q == 3'b110) || (op_q == 3'b111);
    assign arith  = inv_b || (op_q == 3'b000);
    assign last   = (idx == IW'(NIB - 1));
    assign res_nx = {alu_result, res_q[WIDTH-1:4]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        req_ready_i  = 1'b0;
        resp_valid_i = 1'b0;
        alu_a_i      = 4'd0;
        alu_b_i      = 4'd0;
        alu_c_i      = 3'd0;
        alu_cin_i    = 1'b0;
        case (state)
            IDLE: begin
                req_ready_i = 1'b1;
                if (req_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                alu_a_i   = a_q[3:0];
                alu_b_i   = inv_b ? ~b_q[3:0] : b_q[3:0];
                alu_c_i   = arith ? 3'b000 : op_q;
                alu_cin_i = (idx == '0) ? inv_b : (arith & carry_q);
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                resp_valid_i = 1'b1;
                if (resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operands shift right so the current nibble is always at [3:0];
    // results shift in from the top so nibble 0 ends up at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= 3'd0;
            idx     <= '0;
            carry_q <= 1'b0;
            carry_f <= 1'b0;
            ovf_f   <= 1'b0;
            zero_f  <= 1'b0;
            size_f  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_q     <= req_a;
                        b_q     <= req_b;
                        op_q    <= req_op;
                        idx     <= '0;
                        carry_q <= 1'b0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 4;
                    b_q     <= b_q >> 4;
                    res_q   <= res_nx;
                    carry_q <= alu_carry;
                    idx     <= idx + 1'b1;
                    if (last) begin
                        carry_f <= arith & alu_carry;
                        ovf_f   <= arith & alu_overflow;
                        zero_f  <= (res_nx == '0);
                        case (op_q)
                            3'b110:  size_f <= res_nx[WIDTH-1] ^ alu_overflow;
                            3'b111:  size_f <= (res_nx == '0);
                            default: size_f <= 1'b0;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // Every output reads 0 for the whole cycle rst is high, not just after the edge.
    assign req_ready     = req_ready_i & ~rst;
    assign resp_valid    = resp_valid_i & ~rst;
    assign resp_result   = res_q & {WIDTH{~rst}};
    assign resp_carry    = carry_f & ~rst;
    assign resp_overflow = ovf_f & ~rst;
    assign resp_zero     = zero_f & ~rst;
    assign resp_size     = size_f & ~rst;
    assign alu_a         = alu_a_i & {4{~rst}};
    assign alu_b         = alu_b_i & {4{~rst}};
    assign alu_c         = alu_c_i & {3{~rst}};
    assign alu_cin       = alu_cin_i & ~rst;

`ifdef ALU4_NIBBLE_SEQ_OPCNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else if (state == DONE && resp_ready) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign op_count = cnt_q & {16{~rst}};
`endif

endmodule

// File: tb/tb_alu4_nibble_seq.sv
// Scoreboard bench for alu4_nibble_seq with a behavioural 4-bit ALU stand-in.
// Build with ALU4_NIBBLE_SEQ_OPCNT_EN defined to also check op_count.
module tb_alu4_nibble_seq;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a, req_b;
    logic             resp_valid, resp_ready;
    logic [WIDTH-1:0] resp_result;
    logic             resp_carry, resp_overflow, resp_zero, resp_size;
    logic [3:0]       alu_a, alu_b, alu_result;
    logic [2:0]       alu_c;
    logic             alu_cin, alu_carry, alu_overflow;
`ifdef ALU4_NIBBLE_SEQ_OPCNT_EN
    logic [15:0]      op_count;
`endif

    always #5 clk = ~clk;

    alu4_nibble_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_carry(resp_carry), .resp_overflow(resp_overflow),
        .resp_zero(resp_zero), .resp_size(resp_size),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow)
`ifdef ALU4_NIBBLE_SEQ_OPCNT_EN
        , .op_count(op_count)
`endif
    );

    // Stand-in ALU; logic functions report carry/overflow high so that the
    // sequencer's masking of those flags is observable.
    logic [4:0] sum5;
    always_comb begin
        sum5         = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
        alu_result   = 4'd0;
        alu_carry    = 1'b1;
        alu_overflow = 1'b1;
        case (alu_c)
            3'b000: begin
                alu_result   = sum5[3:0];
                alu_carry    = sum5[4];
                alu_overflow = (alu_a[3] == alu_b[3]) && (sum5[3] != alu_a[3]);
            end
            3'b010:  alu_result = ~alu_a;
            3'b011:  alu_result = alu_a & alu_b;
            3'b100:  alu_result = alu_a | alu_b;
            3'b101:  alu_result = alu_a ^ alu_b;
            default: alu_result = 4'd0;
        endcase
    end

    typedef struct {
        string            name;
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             ovf;
        logic             zero;
        logic             size;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   handshakes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst && resp_valid && resp_ready) begin
                handshakes++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_response: got result %0h, expected none", resp_result);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, ".result"},   resp_result,   mon_e.result);
                    check({mon_e.name, ".carry"},    resp_carry,    mon_e.carry);
                    check({mon_e.name, ".overflow"}, resp_overflow, mon_e.ovf);
                    check({mon_e.name, ".zero"},     resp_zero,     mon_e.zero);
                    check({mon_e.name, ".size"},     resp_size,     mon_e.size);
                end
            end
        end
    end

    // Issue one command, push its expectation, check the first RUN cycle's ALU
    // drive and the accept-to-resp_valid latency. Returns #1 after the edge
    // where resp_valid rose.
    task automatic issue(input string name, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] res, input logic c, input logic o,
                         input logic z, input logic s);
        int   n;
        logic subish;
        subish    = (op == 3'b001) || (op == 3'b110) || (op == 3'b111);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, ".req_ready"}, req_ready, 1'b1);
        sb.push_back('{name, res, c, o, z, s});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check({name, ".alu_c"}, alu_c, (subish || op == 3'b000) ? 3'b000 : op);
        check({name, ".alu_cin0"}, alu_cin, subish);
        check({name, ".alu_a0"}, alu_a, a[3:0]);
        check({name, ".ready_run"}, req_ready, 1'b0);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, ".latency"}, n, NIB);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst.req_ready", req_ready, 1'b0);
        check("rst.resp_valid", resp_valid, 1'b0);
        check("rst.alu_bus", {alu_a, alu_b, alu_c, alu_cin}, 12'd0);
        rst = 1'b0;
        #1;
        check("post_rst.req_ready", req_ready, 1'b1);
        check("idle.alu_bus", {alu_a, alu_b, alu_c, alu_cin}, 12'd0);
`ifdef ALU4_NIBBLE_SEQ_OPCNT_EN
        check("post_rst.op_count", op_count, 16'd0);
`endif
        @(posedge clk);
        #1;

        issue("add",      3'b000, 16'h00FF, 16'h0001, 16'h0100, 0, 0, 0, 0);
        issue("add_ovf",  3'b000, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 0);
        issue("add_wrap", 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 0);
        issue("sub_ovf",  3'b001, 16'h8000, 16'h0001, 16'h7FFF, 1, 1, 0, 0);
        issue("sub_brw",  3'b001, 16'h0000, 16'h0001, 16'hFFFF, 0, 0, 0, 0);
        issue("lt_true",  3'b110, 16'hFFFE, 16'h0001, 16'hFFFD, 1, 0, 0, 1);
        issue("lt_false", 3'b110, 16'h0005, 16'hFFFF, 16'h0006, 0, 0, 0, 0);
        issue("eq",       3'b111, 16'h1234, 16'h1234, 16'h0000, 1, 0, 1, 1);
        issue("xor",      3'b101, 16'hF0F0, 16'hFFFF, 16'h0F0F, 0, 0, 0, 0);
        issue("not",      3'b010, 16'h0000, 16'h1234, 16'hFFFF, 0, 0, 0, 0);
        issue("or",       3'b100, 16'h1200, 16'h0034, 16'h1234, 0, 0, 0, 0);

        // Backpressure: response must hold, and a request during DONE is ignored.
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        issue("and_hold", 3'b011, 16'h0F0F, 16'h00FF, 16'h000F, 0, 0, 0, 0);
        req_op    = 3'b000;
        req_a     = 16'h0001;
        req_b     = 16'h0001;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("hold.resp_valid", resp_valid, 1'b1);
            check("hold.resp_result", resp_result, 16'h000F);
            check("hold.req_ready", req_ready, 1'b0);
            check("hold.alu_bus", {alu_a, alu_b, alu_c, alu_cin}, 12'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("after_hs.req_ready", req_ready, 1'b1);
        check("after_hs.resp_valid", resp_valid, 1'b0);
`ifdef ALU4_NIBBLE_SEQ_OPCNT_EN
        check("after_hs.op_count", op_count, handshakes);
`endif
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) n++;
        end
        check("ignored_req.no_resp", n, 0);

        // Reset during nibble 2 abandons the operation.
        req_op    = 3'b000;
        req_a     = 16'h1111;
        req_b     = 16'h2222;
        req_valid = 1'b1;
        @(negedge clk);
        check("rst_run.req_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_run.alu_a_nib2", alu_a, 4'h1);
        rst = 1'b1;
        #1;
        check("rst_run.req_ready", req_ready, 1'b0);
        check("rst_run.resp_valid", resp_valid, 1'b0);
        check("rst_run.resp_result", resp_result, 16'h0000);
        check("rst_run.alu_bus", {alu_a, alu_b, alu_c, alu_cin}, 12'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_run.ready_after", req_ready, 1'b1);
`ifdef ALU4_NIBBLE_SEQ_OPCNT_EN
        check("rst_run.op_count", op_count, 16'd0);
`endif
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) n++;
        end
        check("rst_run.no_resp", n, 0);

        issue("add_after_rst", 3'b000, 16'h0001, 16'h0001, 16'h0002, 0, 0, 0, 0);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
